serial_to_word16: RTL and testbench

- Receiving end of the team's bit-serial word link. The transmit side selects one bit per cycle out of a 16-bit word.
- This block accepts one bit per handshake, shifts the bits LSB-first into a word, and hands each complete word downstream through a one-entry output buffer.
- It sits between any bit-serial source and the 16-bit datapath built from the elementary gate library.

---
 rtl/serial_to_word16_pkg.sv | 14 +
 rtl/serial_to_word16_if.sv | 30 +++
 rtl/serial_to_word16_word_out_buffer.sv | 28 ++
 rtl/serial_to_word16.sv | 105 ++++++++++
 tb/tb_serial_to_word16.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_to_word16_pkg.sv
// Shared definitions for the bit-serial word link (receive and transmit sides).
package serial_link_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] STALL   = 1'b1;

  // Position inside the word that the count-th serial bit occupies.
  function automatic int bit_index(input int count, input int width, input bit lsb_first);
    return lsb_first ? count : (width - 1 - count);
  endfunction

endpackage

// File: rtl/serial_to_word16_if.sv
// Bit-serial input handshake plus word output handshake of the deserializer.
interface serial_to_word16_if
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int CW = $clog2(WIDTH);

  logic          in_valid;
  logic          in_ready;
  logic          in_bit;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CW-1:0] bit_count;
  logic          dropped;

  modport master (
    output in_valid, in_bit, in_sof, out_ready,
    input  in_ready, out_valid, out_word, bit_count, dropped
  );

  modport slave (
    input  in_valid, in_bit, in_sof, out_ready,
    output in_ready, out_valid, out_word, bit_count, dropped
  );

endinterface

// File: rtl/serial_to_word16_word_out_buffer.sv
// One-entry valid/ready word register.
// Latency: load visible one cycle later.
// Backpressure: holds word stable while full && !out_ready; caller loads only when empty or draining.
module word_out_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] out_word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      out_word <= '0;
    end else if (load) begin
      full     <= 1'b1;
      out_word <= load_data;
    end else if (full && out_ready) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_word16.sv
// Bit-serial to WIDTH-bit word deserializer with one-entry output buffer.
// Latency: word valid the cycle after its last bit is accepted; one bit/cycle sustained.
// Backpressure: completed word waits in the shift register (in_ready=0) while the buffer is blocked.
module serial_to_word16
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  serial_to_word16_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, word_nxt, load_data, buf_word;
  logic [CW-1:0]    cnt, cnt_nxt, eff_cnt, wr_idx;
  logic             dropped_q, dropped_nxt;
  logic             in_xfer, out_xfer, sof_restart, load, full;

  assign bus.in_ready = (state == COLLECT);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = full && bus.out_ready;

  // A start-of-frame on a partial word restarts assembly with this bit as bit 0.
  assign sof_restart  = bus.in_sof && (cnt != '0);
  assign eff_cnt      = sof_restart ? '0 : cnt;
  assign wr_idx       = CW'(bit_index(int'(eff_cnt), WIDTH, LSB_FIRST));

  always_comb begin
    word_nxt         = sof_restart ? '0 : shreg;
    word_nxt[wr_idx] = bus.in_bit;
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    load        = 1'b0;
    load_data   = shreg;
    dropped_nxt = 1'b0;
    if (state == COLLECT) begin
      if (in_xfer) begin
        dropped_nxt = sof_restart;
        if (eff_cnt == LAST) begin
          if (!full || out_xfer) begin
            load      = 1'b1;
            load_data = word_nxt;
            shreg_nxt = '0;
            cnt_nxt   = '0;
          end else begin
            shreg_nxt = word_nxt;
            cnt_nxt   = LAST;
            state_nxt = STALL;
          end
        end else begin
          shreg_nxt = word_nxt;
          cnt_nxt   = eff_cnt + CW'(1);
        end
      end
    end else if (out_xfer) begin
      // Buffer drains this cycle; refill it from the held word without a bubble.
      load      = 1'b1;
      load_data = shreg;
      shreg_nxt = '0;
      cnt_nxt   = '0;
      state_nxt = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      shreg     <= '0;
      cnt       <= '0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      dropped_q <= dropped_nxt;
    end
  end

  word_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .out_ready(bus.out_ready),
    .full     (full),
    .out_word (buf_word)
  );

  assign bus.out_valid = full;
  assign bus.out_word  = buf_word;
  assign bus.bit_count = cnt;
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_serial_to_word16.sv
// Directed and randomly throttled checks of serial_to_word16 (LSB-first and MSB-first instances).
module tb_serial_to_word16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_to_word16_if #(.WIDTH(16)) b1 ();
  serial_to_word16_if #(.WIDTH(16)) b2 ();

  serial_to_word16 #(.WIDTH(16), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  serial_to_word16 #(.WIDTH(16), .LSB_FIRST(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic [15:0] word;
    int          pre_bits;
    logic        pre_val;
    logic [15:0] exp_word;
    int          exp_drops;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] words[1000];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic b, input logic sof);
    b1.in_valid = 1'b1;
    b1.in_bit   = b;
    b1.in_sof   = sof;
    tick();
    b1.in_valid = 1'b0;
    b1.in_sof   = 1'b0;
  endtask

  task automatic send2(input logic b);
    b2.in_valid = 1'b1;
    b2.in_bit   = b;
    tick();
    b2.in_valid = 1'b0;
  endtask

  task automatic send_word1(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send1(w[i], 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    int          drops;
    logic        irdy_ok;
    int          tx_w, tx_b, rx, cyc;
    logic        hold_vld;
    logic [15:0] hold_word;

    vecs[0] = '{16'hA5C3,  0, 1'b0, 16'hA5C3, 0};
    vecs[1] = '{16'h1234,  5, 1'b1, 16'h1234, 1};
    vecs[2] = '{16'hFFFF,  0, 1'b0, 16'hFFFF, 0};
    vecs[3] = '{16'h0000, 15, 1'b1, 16'h0000, 1};
    vecs[4] = '{16'h8001,  1, 1'b1, 16'h8001, 1};

    reset = 1'b1;
    b1.in_valid = 1'b0; b1.in_bit = 1'b0; b1.in_sof = 1'b0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_bit = 1'b0; b2.in_sof = 1'b0; b2.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("rst_out_word",  32'(b1.out_word),  32'd0);
    check("rst_bit_count", 32'(b1.bit_count), 32'd0);
    check("rst_dropped",   32'(b1.dropped),   32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(b1.in_ready), 32'd1);

    // Table: optional partial prefix, then a full word whose first bit carries in_sof.
    b1.out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      drops   = 0;
      irdy_ok = 1'b1;
      for (int i = 0; i < vecs[r].pre_bits; i++) begin
        send1(vecs[r].pre_val, 1'b0);
        drops += int'(b1.dropped);
      end
      check("vec_pre_count", 32'(b1.bit_count), 32'(vecs[r].pre_bits));
      for (int i = 0; i < 16; i++) begin
        send1(vecs[r].word[i], i == 0);
        drops += int'(b1.dropped);
        irdy_ok &= b1.in_ready;
        if (i == 0)  check("vec_sof_count", 32'(b1.bit_count), 32'd1);
        if (i == 14) check("vec_early_valid", 32'(b1.out_valid), 32'd0);
      end
      check("vec_out_valid", 32'(b1.out_valid), 32'd1);
      check("vec_out_word",  32'(b1.out_word),  32'(vecs[r].exp_word));
      check("vec_count_zero", 32'(b1.bit_count), 32'd0);
      check("vec_drops",     32'(drops),        32'(vecs[r].exp_drops));
      check("vec_in_ready",  32'(irdy_ok),      32'd1);
      tick();
      check("vec_drained",   32'(b1.out_valid), 32'd0);
    end

    // Two words against a blocked sink: second word parks in STALL.
    b1.out_ready = 1'b0;
    send_word1(16'h0001);
    check("bb_first_valid", 32'(b1.out_valid), 32'd1);
    check("bb_first_word",  32'(b1.out_word),  32'h0001);
    send_word1(16'h8000);
    check("bb_stall_rdy",   32'(b1.in_ready),  32'd0);
    check("bb_stall_cnt",   32'(b1.bit_count), 32'd15);
    b1.in_valid = 1'b1;
    b1.in_bit   = 1'b1;
    tick();
    tick();
    b1.in_valid = 1'b0;
    check("bb_hold_word",   32'(b1.out_word),  32'h0001);
    check("bb_hold_valid",  32'(b1.out_valid), 32'd1);
    check("bb_hold_rdy",    32'(b1.in_ready),  32'd0);
    b1.out_ready = 1'b1;
    #1;
    check("bb_no_comb_rdy", 32'(b1.in_ready),  32'd0);
    tick();
    check("bb_second_valid", 32'(b1.out_valid), 32'd1);
    check("bb_second_word",  32'(b1.out_word),  32'h8000);
    check("bb_resume_rdy",   32'(b1.in_ready),  32'd1);
    check("bb_resume_cnt",   32'(b1.bit_count), 32'd0);
    tick();
    check("bb_drained",      32'(b1.out_valid), 32'd0);

    // MSB-first instance.
    for (int i = 0; i < 16; i++) send2(i == 0);
    check("msb_out_valid", 32'(b2.out_valid), 32'd1);
    check("msb_out_word",  32'(b2.out_word),  32'h8000);
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      send2(w[i]);
      if (i == 0) check("msb_count", 32'(b2.bit_count), 32'd1);
    end
    check("msb_rev_word", 32'(b2.out_word), 32'hC3A5);

    // Asynchronous reset mid-cycle while stalled with a full buffer.
    b1.out_ready = 1'b0;
    send_word1(16'hFFFF);
    send_word1(16'hFFFF);
    check("ar_pre_rdy",   32'(b1.in_ready),  32'd0);
    check("ar_pre_valid", 32'(b1.out_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(b1.out_valid), 32'd0);
    check("ar_out_word",  32'(b1.out_word),  32'd0);
    check("ar_bit_count", 32'(b1.bit_count), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("ar_in_ready",  32'(b1.in_ready),  32'd1);
    b1.out_ready = 1'b1;
    send_word1(16'h5A3C);
    check("ar_recover_word", 32'(b1.out_word), 32'h5A3C);
    tick();

    // Randomly throttled stream scored against the words sent.
    for (int i = 0; i < 1000; i++) words[i] = 16'($urandom);
    tx_w = 0; tx_b = 0; rx = 0; cyc = 0;
    hold_vld = 1'b0;
    hold_word = '0;
    b1.in_sof = 1'b0;
    while (rx < 1000 && cyc < 60000) begin
      b1.in_valid = (tx_w < 1000) && ($urandom_range(0, 3) != 0);
      if (tx_w < 1000) b1.in_bit = words[tx_w][tx_b];
      b1.out_ready = ($urandom_range(0, 9) < 7);
      if (hold_vld) check("rand_stable", 32'({b1.out_valid, b1.out_word}), 32'({1'b1, hold_word}));
      hold_vld  = b1.out_valid && !b1.out_ready;
      hold_word = b1.out_word;
      if (b1.out_valid && b1.out_ready) begin
        check("rand_word", 32'(b1.out_word), 32'(words[rx]));
        rx++;
      end
      if (b1.in_valid && b1.in_ready) begin
        tx_b++;
        if (tx_b == 16) begin
          tx_b = 0;
          tx_w++;
        end
      end
      tick();
      cyc++;
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b0;
    check("rand_count", 32'(rx), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
